// File: rtl/register_file_sb.sv
// register_file_sb: 2-read / 1-write register file with hardwired zero entry,
// optional write-to-read bypass, per-entry busy scoreboard and a one-entry-per-cycle
// clear sequencer. Decode side reads and reserves; writeback side drives WE3/A3/WD3.

// One storage entry: data word plus its pending-writeback busy flag.
module register_file_sb_entry #(
    parameter int DATA_WIDTH = 32,
    parameter bit HARD_ZERO  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic                  clr_en,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic                  busy_flush,
    input  logic                  busy_set,
    input  logic                  busy_drop,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  busy
);

    // Data word: a hardwired-zero entry never leaves 0; the sequencer clear beats a write.
    always_ff @(posedge CLK) begin
        if (RST || HARD_ZERO)
            q <= '0;
        else if (clr_en)
            q <= '0;
        else if (wr_en)
            q <= wd;
    end

    // Busy flag: a new reservation outlives a writeback landing in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST || HARD_ZERO || busy_flush)
            busy <= 1'b0;
        else if (busy_set)
            busy <= 1'b1;
        else if (busy_drop)
            busy <= 1'b0;
    end

endmodule

module register_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    input  logic                  WE3,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic                  RSV_EN,
    input  logic [ADDR_WIDTH-1:0] RSV_ADDR,
    output logic                  BUSY1,
    output logic                  BUSY2,
    input  logic                  CLR_REQ,
    output logic                  CLR_BUSY
);

    localparam int                    DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST  = '1;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    state_t                               state;
    logic [ADDR_WIDTH-1:0]                cnt;
    logic                                 clr_busy_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]     mem_q;
    logic [DEPTH-1:0]                     busy_q;

    logic idle, wr_ok, rsv_ok, flush;
    logic zero1, zero2, byp1, byp2;

    // Writeback, reservations and the flush only act while the sequencer is idle.
    assign idle   = (state == IDLE);
    assign wr_ok  = idle && WE3;
    assign rsv_ok = idle && RSV_EN;
    assign flush  = idle && CLR_REQ;

    // Clear sequencer: walks cnt over every entry once, then returns to IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            cnt        <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CLR_REQ) begin
                        state      <= CLEAR;
                        cnt        <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        clr_busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    assign CLR_BUSY = clr_busy_q;

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_ent
            register_file_sb_entry #(
                .DATA_WIDTH (DATA_WIDTH),
                .HARD_ZERO  ((ZERO_REG != 0) && (i == 0))
            ) u_ent (
                .CLK        (CLK),
                .RST        (RST),
                .wr_en      (wr_ok && (A3 == ADDR_WIDTH'(i))),
                .clr_en     (!idle && (cnt == ADDR_WIDTH'(i))),
                .wd         (WD3),
                .busy_flush (flush),
                .busy_set   (rsv_ok && (RSV_ADDR == ADDR_WIDTH'(i))),
                .busy_drop  (wr_ok && (A3 == ADDR_WIDTH'(i))),
                .q          (mem_q[i]),
                .busy       (busy_q[i])
            );
        end
    endgenerate

    // Per-port zero-register and bypass-match detection.
    always_comb begin
        zero1 = (ZERO_REG != 0) && (A1 == '0);
        zero2 = (ZERO_REG != 0) && (A2 == '0);
        byp1  = (BYPASS != 0) && wr_ok && (A3 == A1) && !zero1;
        byp2  = (BYPASS != 0) && wr_ok && (A3 == A2) && !zero2;
    end

    // A forwarded value is by definition no longer pending, so its busy reads 0.
    assign RD1   = zero1 ? '0 : (byp1 ? WD3 : mem_q[A1]);
    assign RD2   = zero2 ? '0 : (byp2 ? WD3 : mem_q[A2]);
    assign BUSY1 = idle && !byp1 && busy_q[A1];
    assign BUSY2 = idle && !byp2 && busy_q[A2];

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed scenarios plus randomized traffic against an
// array-based reference of the register file, scoreboard and clear sequence.
module tb_register_file_sb;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  A1, A2, A3, RSV_ADDR;
    logic [31:0] WD3, RD1, RD2;
    logic        WE3, RSV_EN, CLR_REQ;
    logic        BUSY1, BUSY2, CLR_BUSY;

    register_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .CLK(CLK), .RST(RST), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .WE3(WE3), .A3(A3), .WD3(WD3), .RSV_EN(RSV_EN), .RSV_ADDR(RSV_ADDR),
        .BUSY1(BUSY1), .BUSY2(BUSY2), .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY)
    );

    always #5 CLK = ~CLK;

    // Reference state
    logic [31:0] m_mem [32];
    bit          m_busy[32];
    bit          m_clr;
    int          m_left;   // entries still to be cleared
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (!m_clr && WE3 && A3 == a) return WD3;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        if (m_clr || a == 0) return 32'h0;
        if (WE3 && A3 == a) return 32'h0;
        return {31'h0, m_busy[a]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 32; k++) begin
            m_mem[k]  = 32'h0;
            m_busy[k] = 1'b0;
        end
        m_clr  = 1'b0;
        m_left = 0;
    endtask

    // Apply the effect of the coming clock edge to the reference.
    task automatic model_edge();
        if (RST) begin
            model_reset();
        end else if (m_clr) begin
            m_mem[32 - m_left] = 32'h0;
            m_left--;
            if (m_left == 0) m_clr = 1'b0;
        end else begin
            if (WE3 && A3 != 0) m_mem[A3] = WD3;
            if (WE3) m_busy[A3] = 1'b0;
            if (RSV_EN && RSV_ADDR != 0) m_busy[RSV_ADDR] = 1'b1;
            if (CLR_REQ) begin
                for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
                m_clr  = 1'b1;
                m_left = 32;
            end
        end
    endtask

    // Check all outputs against the reference, then advance one clock.
    task automatic step(input string tag);
        #2;
        chk({tag, " RD1"},      RD1,              exp_rd(A1));
        chk({tag, " RD2"},      RD2,              exp_rd(A2));
        chk({tag, " BUSY1"},    {31'h0, BUSY1},   exp_busy(A1));
        chk({tag, " BUSY2"},    {31'h0, BUSY2},   exp_busy(A2));
        chk({tag, " CLR_BUSY"}, {31'h0, CLR_BUSY}, {31'h0, m_clr});
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        RST = 0; WE3 = 0; RSV_EN = 0; CLR_REQ = 0;
    endtask

    int clr_cycles;

    initial begin
        quiet();
        RST = 1; A1 = 0; A2 = 0; A3 = 0; RSV_ADDR = 0; WD3 = 0;
        model_reset();
        @(posedge CLK); #1;
        RST = 0;

        // 1: post-reset state
        A1 = 5; A2 = 31;
        #1;
        chk("t1 rd1", RD1, 32'h0);
        chk("t1 rd2", RD2, 32'h0);
        chk("t1 busy", {29'h0, BUSY1, BUSY2, CLR_BUSY}, 32'h0);
        step("t1");

        // 2: bypass then stored value
        WE3 = 1; A3 = 7; WD3 = 32'hDEADBEEF; A1 = 7;
        #1 chk("t2 bypass", RD1, 32'hDEADBEEF);
        step("t2a");
        WE3 = 0;
        #1 chk("t2 stored", RD1, 32'hDEADBEEF);
        step("t2b");

        // 3: zero register ignores writes
        WE3 = 1; A3 = 0; WD3 = 32'h1234; step("t3a");
        WE3 = 0; A1 = 0;
        #1 chk("t3 zero", RD1, 32'h0);
        step("t3b");

        // 4: scoreboard
        RSV_EN = 1; RSV_ADDR = 9; A1 = 9; step("t4a");
        RSV_EN = 0;
        #1 chk("t4 rsv", {31'h0, BUSY1}, 32'h1);
        step("t4b");
        WE3 = 1; A3 = 9; WD3 = 32'h99;
        #1 chk("t4 wb same", {31'h0, BUSY1}, 32'h0);
        step("t4c");
        WE3 = 0;
        #1 chk("t4 wb after", {31'h0, BUSY1}, 32'h0);
        step("t4d");
        RSV_EN = 1; RSV_ADDR = 9; WE3 = 1; A3 = 9; WD3 = 32'h77; step("t4e");
        quiet();
        #1 chk("t4 set wins", {31'h0, BUSY1}, 32'h1);
        step("t4f");

        // 5: fill, clear, count CLR_BUSY cycles
        for (int r = 1; r < 32; r++) begin
            WE3 = 1; A3 = 5'(r); WD3 = $urandom; A1 = 5'(r); A2 = 5'($urandom_range(0, 31));
            step("t5 fill");
        end
        WE3 = 0; CLR_REQ = 1; step("t5 req");
        clr_cycles = 0;
        for (int k = 0; k < 34; k++) begin
            WE3 = (k < 32); A3 = 5'($urandom_range(1, 31)); WD3 = $urandom;
            RSV_EN = (k < 32); RSV_ADDR = 5'($urandom_range(1, 31));
            CLR_REQ = (k < 31) && $urandom_range(0, 1) == 1;
            A1 = A3; A2 = RSV_ADDR;
            #1 clr_cycles += int'(CLR_BUSY);
            step("t5 clr");
        end
        quiet();
        chk("t5 clr len", clr_cycles, 32);
        for (int r = 0; r < 32; r++) begin
            A1 = 5'(r); A2 = 5'(31 - r);
            #1 chk("t5 zeroed", RD1 | RD2, 32'h0);
            step("t5 read");
        end

        // 6: reset in the middle of a clear
        for (int r = 20; r < 32; r++) begin
            WE3 = 1; A3 = 5'(r); WD3 = $urandom | 32'h1; step("t6 fill");
        end
        WE3 = 0; RSV_EN = 1; RSV_ADDR = 25; step("t6 rsv");
        RSV_EN = 0; CLR_REQ = 1; step("t6 req");
        CLR_REQ = 0;
        for (int k = 0; k < 10; k++) step("t6 clr");
        RST = 1; step("t6 rst");
        RST = 0;
        #1 chk("t6 clr_busy", {31'h0, CLR_BUSY}, 32'h0);
        for (int r = 0; r < 32; r++) begin
            A1 = 5'(r); A2 = 5'(r);
            #1 chk("t6 zeroed", RD1 | {31'h0, BUSY1}, 32'h0);
            step("t6 read");
        end

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            RST      = ($urandom_range(0, 199) == 0);
            CLR_REQ  = ($urandom_range(0, 79) == 0);
            WE3      = $urandom_range(0, 1) == 1;
            RSV_EN   = $urandom_range(0, 2) == 0;
            A3       = 5'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 31));
            RSV_ADDR = 5'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 31));
            A1       = 5'(($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 31));
            A2       = 5'(($urandom_range(0, 1) == 1) ? A3 : 5'($urandom_range(0, 31)));
            WD3      = $urandom;
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
